lb_window_ctrl: RTL and testbench

Sequencing controller for the 5-row `LineBuffer` in the convolution front end. It runs a frame-level FSM and admits pixels from the upstream source only when the downstream window consumer can accept them. It drives the line buffer write enable and tracks the pixel column and row. It also decides which accepted pixels complete a valid K×K window for the configured stride, tagging each one with output coordinates. It sits between the pixel source and the `LineBuffer` and window-register datapath, and reports frame completion to the layer scheduler.

---
 rtl/lb_window_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_lb_window_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lb_window_ctrl.sv
// lb_window_ctrl
// Frame sequencer for the K-row line buffer in the convolution front end.
// It admits pixels only while the window consumer is ready, tracks the pixel
// column/row, and tags each accepted pixel that completes a KxK window at the
// configured stride with output-space coordinates.
//
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   start          : one-cycle frame start, honoured only in IDLE
//   pix_valid      : upstream pixel available
//   pix_ready      : controller accepts a pixel this cycle (combinational)
//   out_ready      : downstream window consumer can take windows
//   lb_wr_en       : pix_valid & pix_ready, drives the line buffer in_valid
//   win_valid      : registered; line buffer outputs form a valid window
//   win_x, win_y   : output-space coordinates of the current window
//   busy           : high in FILL and RUN
//   done           : one-cycle pulse at frame end
module lb_window_ctrl #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic          out_ready,
  output logic          lb_wr_en,
  output logic          win_valid,
  output logic [CW-1:0] win_x,
  output logic [CW-1:0] win_y,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_MAX = CW'(IMG_H - 1);
  localparam logic [CW-1:0] KM1     = CW'(K - 1);
  localparam logic [CW-1:0] KM2     = CW'(K - 2);
  localparam logic [CW-1:0] PH_MAX  = CW'(STRIDE - 1);
  localparam logic [CW-1:0] ZERO    = {CW{1'b0}};

  state_t        state_r;
  logic [CW-1:0] col_r;
  logic [CW-1:0] row_r;
  logic [CW-1:0] ph_c_r;
  logic [CW-1:0] ph_r_r;
  logic [CW-1:0] x_cnt_r;        // index the next emitted window will carry
  logic [CW-1:0] y_cnt_r;
  logic          row_emitted_r;  // current row has produced at least one window

  logic active_s;
  logic accept_s;
  logic row_wrap_s;
  logic last_pix_s;
  logic col_in_s;
  logic row_in_s;
  logic qualify_s;

  // Stride phase step: counts 0..STRIDE-1 and wraps, avoiding any modulo.
  function automatic logic [CW-1:0] phase_step(input logic [CW-1:0] ph);
    logic [CW-1:0] nxt;
    if (ph == PH_MAX) begin
      nxt = ZERO;
    end else begin
      nxt = ph + CW'(1);
    end
    return nxt;
  endfunction

  assign active_s   = (state_r == ST_FILL) || (state_r == ST_RUN);
  assign pix_ready  = active_s & out_ready;
  assign lb_wr_en   = pix_valid & pix_ready;
  assign accept_s   = lb_wr_en;
  assign row_wrap_s = accept_s & (col_r == COL_MAX);
  assign last_pix_s = row_wrap_s & (row_r == ROW_MAX);
  assign col_in_s   = (col_r >= KM1);
  assign row_in_s   = (row_r >= KM1);
  assign qualify_s  = accept_s & col_in_s & row_in_s &
                      (ph_c_r == ZERO) & (ph_r_r == ZERO);

  // Frame FSM with registered busy/done/win_valid outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_valid <= 1'b0;
    end else begin
      // Window for an accepted pixel appears exactly one cycle later.
      win_valid <= qualify_s;
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r <= ST_FILL;
            busy    <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_FILL: begin
          if (row_wrap_s && (row_r == KM2)) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_FILL;
          end
        end
        ST_RUN: begin
          if (last_pix_s) begin
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Pixel position, stride phase and window coordinate tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r         <= ZERO;
      row_r         <= ZERO;
      ph_c_r        <= ZERO;
      ph_r_r        <= ZERO;
      x_cnt_r       <= ZERO;
      y_cnt_r       <= ZERO;
      row_emitted_r <= 1'b0;
      win_x         <= ZERO;
      win_y         <= ZERO;
    end else begin
      // Published coordinates only change together with a new window.
      if (qualify_s) begin
        win_x <= x_cnt_r;
        win_y <= y_cnt_r;
      end else begin
        win_x <= win_x;
        win_y <= win_y;
      end

      if (last_pix_s) begin
        // Frame complete: leave everything at zero for the next start.
        col_r         <= ZERO;
        row_r         <= ZERO;
        ph_c_r        <= ZERO;
        ph_r_r        <= ZERO;
        x_cnt_r       <= ZERO;
        y_cnt_r       <= ZERO;
        row_emitted_r <= 1'b0;
      end else if (row_wrap_s) begin
        col_r         <= ZERO;
        row_r         <= row_r + CW'(1);
        ph_c_r        <= ZERO;
        ph_r_r        <= row_in_s ? phase_step(ph_r_r) : ph_r_r;
        x_cnt_r       <= ZERO;
        // Only rows that emitted windows advance the output row.
        y_cnt_r       <= (row_emitted_r || qualify_s) ? (y_cnt_r + CW'(1)) : y_cnt_r;
        row_emitted_r <= 1'b0;
      end else if (accept_s) begin
        col_r         <= col_r + CW'(1);
        ph_c_r        <= col_in_s ? phase_step(ph_c_r) : ph_c_r;
        x_cnt_r       <= qualify_s ? (x_cnt_r + CW'(1)) : x_cnt_r;
        row_emitted_r <= row_emitted_r | qualify_s;
      end else begin
        col_r         <= col_r;
        row_r         <= row_r;
      end
    end
  end

endmodule

// File: tb/tb_lb_window_ctrl.sv
// Directed bench for lb_window_ctrl: an 8x8 frame with K=5, run through a
// STRIDE=1 and a STRIDE=2 instance driven by the same stimulus. Expected
// windows come from per-stride tables of {trigger pixel, window coordinates}.
module tb_lb_window_ctrl;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int K  = 5;
  localparam int CW = 8;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic pix_valid;
  logic out_ready;

  logic          pr1, we1, wv1, busy1, done1;
  logic [CW-1:0] wx1, wy1;
  logic          pr2, we2, wv2, busy2, done2;
  logic [CW-1:0] wx2, wy2;

  typedef struct {
    int px;
    int py;
    int wx;
    int wy;
  } win_t;

  win_t tab1[16];
  win_t tab2[4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lb_window_ctrl #(.IMG_W(W), .IMG_H(H), .K(K), .STRIDE(1), .CW(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
    .pix_ready(pr1), .out_ready(out_ready), .lb_wr_en(we1), .win_valid(wv1),
    .win_x(wx1), .win_y(wy1), .busy(busy1), .done(done1)
  );

  lb_window_ctrl #(.IMG_W(W), .IMG_H(H), .K(K), .STRIDE(2), .CW(CW)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
    .pix_ready(pr2), .out_ready(out_ready), .lb_wr_en(we2), .win_valid(wv2),
    .win_x(wx2), .win_y(wy2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One frame. toggle: pix_valid alternates; stall_at: pixel index at which
  // out_ready drops for 3 cycles; start_mid: pixel index during which start is
  // held; abort_at: pixel count after which rst_n is pulsed; start_in_done:
  // pulse start during the DONE cycle.
  task automatic run_frame(input bit toggle, input int stall_at, input int start_mid,
                           input int abort_at, input bit start_in_done);
    int n = 0;
    int i1 = 0;
    int i2 = 0;
    int stall_cnt = 0;
    int x;
    int y;
    bit stalled = 1'b0;
    bit ph = 1'b1;
    bit acc;

    start = 1'b1; pix_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("idle_wr_en", 32'(we1), 0);
    chk("idle_ready", 32'(pr1), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy1), 1);
    chk("busy_after_start2", 32'(busy2), 1);

    for (int cyc = 0; cyc < 600 && n < NPIX; cyc++) begin
      if (abort_at >= 0 && n == abort_at) begin
        pix_valid = 1'b1; out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(pr1), 0);
        chk("rst_wr_en", 32'(we1), 0);
        chk("rst_win_valid", 32'(wv1), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_done", 32'(done1), 0);
        chk("rst_win_x", 32'(wx1), 0);
        chk("rst_win_y", 32'(wy1), 0);
        chk("rst_busy2", 32'(busy2), 0);
        for (int r = 0; r < 3; r++) begin
          @(posedge clk); #1;
          chk("rst_no_done", 32'(done1), 0);
        end
        rst_n = 1'b1;
        pix_valid = 1'b0;
        return;
      end
      pix_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      if (!stalled && stall_at >= 0 && n == stall_at) begin
        stalled = 1'b1;
        stall_cnt = 3;
      end
      out_ready = (stall_cnt > 0) ? 1'b0 : 1'b1;
      if (stall_cnt > 0) stall_cnt--;
      start = (n == start_mid);
      #1;
      acc = pix_valid && out_ready;
      chk("wr_en", 32'(we1), 32'(acc));
      chk("wr_en2", 32'(we2), 32'(acc));
      chk("ready", 32'(pr1), 32'(out_ready));
      @(posedge clk); #1;
      if (acc) begin
        x = n % W;
        y = n / W;
        n++;
        if (i1 < 16 && tab1[i1].px == x && tab1[i1].py == y) begin
          chk("win_valid1", 32'(wv1), 1);
          chk("win_x1", 32'(wx1), 32'(tab1[i1].wx));
          chk("win_y1", 32'(wy1), 32'(tab1[i1].wy));
          i1++;
        end else begin
          chk("win_valid1", 32'(wv1), 0);
        end
        if (i2 < 4 && tab2[i2].px == x && tab2[i2].py == y) begin
          chk("win_valid2", 32'(wv2), 1);
          chk("win_x2", 32'(wx2), 32'(tab2[i2].wx));
          chk("win_y2", 32'(wy2), 32'(tab2[i2].wy));
          i2++;
        end else begin
          chk("win_valid2", 32'(wv2), 0);
        end
      end else begin
        chk("win_valid1_idle", 32'(wv1), 0);
        chk("win_valid2_idle", 32'(wv2), 0);
      end
    end

    // Cycle after the last accept: DONE state.
    start = 1'b0;
    chk("frame_len", 32'(n), 32'(NPIX));
    chk("win_count1", 32'(i1), 16);
    chk("win_count2", 32'(i2), 4);
    chk("done1", 32'(done1), 1);
    chk("done2", 32'(done2), 1);
    chk("busy_at_done", 32'(busy1), 0);
    pix_valid = 1'b1; out_ready = 1'b1; start = start_in_done;
    #1;
    chk("done_ready", 32'(pr1), 0);
    chk("done_wr_en", 32'(we1), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse_end", 32'(done1), 0);
    chk("idle_busy", 32'(busy1), 0);
    chk("idle_win_valid", 32'(wv1), 0);
    chk("idle_wr_en_after", 32'(we1), 0);
  endtask

  task automatic idle_cycles(input int nc, input bit pv);
    for (int i = 0; i < nc; i++) begin
      pix_valid = pv; out_ready = 1'b1; start = 1'b0;
      #1;
      chk("idle_no_accept", 32'(we1), 0);
      @(posedge clk); #1;
      chk("idle_no_window", 32'(wv1), 0);
      chk("idle_not_busy", 32'(busy1), 0);
    end
  endtask

  initial begin
    int k = 0;
    for (int yy = 4; yy < H; yy++) begin
      for (int xx = 4; xx < W; xx++) begin
        tab1[k] = '{px: xx, py: yy, wx: xx - 4, wy: yy - 4};
        k++;
      end
    end
    tab2[0] = '{px: 4, py: 4, wx: 0, wy: 0};
    tab2[1] = '{px: 6, py: 4, wx: 1, wy: 0};
    tab2[2] = '{px: 4, py: 6, wx: 0, wy: 1};
    tab2[3] = '{px: 6, py: 6, wx: 1, wy: 1};

    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("reset_busy", 32'(busy1), 0);
    chk("reset_done", 32'(done1), 0);
    chk("reset_win_valid", 32'(wv1), 0);
    chk("reset_ready", 32'(pr1), 0);
    chk("reset_win_x", 32'(wx1), 0);
    chk("reset_win_y", 32'(wy1), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(2, 1'b0);

    // 1+2: continuous stream, both strides
    run_frame(1'b0, -1, -1, -1, 1'b0);
    idle_cycles(3, 1'b0);
    // 3: toggling pix_valid with a 3-cycle backpressure mid row 5
    run_frame(1'b1, 42, -1, -1, 1'b0);
    idle_cycles(3, 1'b0);
    // 4: pix_valid in IDLE, start during RUN and during DONE
    idle_cycles(5, 1'b1);
    run_frame(1'b0, -1, 30, -1, 1'b1);
    idle_cycles(2, 1'b1);
    // 5: reset after 30 accepted pixels, then a clean frame
    run_frame(1'b0, -1, -1, 30, 1'b0);
    idle_cycles(2, 1'b0);
    run_frame(1'b0, -1, -1, -1, 1'b0);
    idle_cycles(2, 1'b0);
    // 6: back-to-back frames, start on the first IDLE cycle after done
    run_frame(1'b0, -1, -1, -1, 1'b0);
    run_frame(1'b0, -1, -1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
